id_ex_pipeline_reg: RTL and testbench

- Decode-to-execute pipeline register of the 5-stage RV32I core.
- Captures decode-stage control outputs (RegWriteD, ResultSrcD, MemWriteD, ALUControlD, ALUSrcD, Jump/Branch qualifiers) and decode-stage datapath values, and presents them to the execute stage one cycle later.
- Supports a stall (hold) and a flush (bubble insertion) driven by the hazard unit.
- Keeps a saturating bubble counter and a valid bit for debug and verification.

---
 rtl/id_ex_pipeline_reg.sv | 204 ++++++++++++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register of the 5-stage RV32I core: one-cycle registered copy of
// decode control and datapath fields, with hazard-unit stall/flush and a bubble counter.
module id_ex_pipeline_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      StallE,
  input  logic                      FlushE,
  input  logic                      ValidD,
  input  logic                      RegWriteD,
  input  logic [1:0]                ResultSrcD,
  input  logic [2:0]                MemWriteD,
  input  logic [2:0]                ALUControlD,
  input  logic                      ALUSrcD,
  input  logic                      JumpD,
  input  logic                      BranchD,
  input  logic                      JalrD,
  input  logic [2:0]                Funct3D,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [DATA_WIDTH-1:0]     PCPlus4D,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  output logic                      ValidE,
  output logic                      RegWriteE,
  output logic [1:0]                ResultSrcE,
  output logic [2:0]                MemWriteE,
  output logic [2:0]                ALUControlE,
  output logic                      ALUSrcE,
  output logic                      JumpE,
  output logic                      BranchE,
  output logic                      JalrE,
  output logic [2:0]                Funct3E,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [DATA_WIDTH-1:0]     PCPlus4E,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic [CNT_WIDTH-1:0]      BubbleCount
);

  logic                      valid_d, valid_q;
  logic                      reg_write_d, reg_write_q;
  logic [1:0]                result_src_d, result_src_q;
  logic [2:0]                mem_write_d, mem_write_q;
  logic [2:0]                alu_control_d, alu_control_q;
  logic                      alu_src_d, alu_src_q;
  logic                      jump_d, jump_q;
  logic                      branch_d, branch_q;
  logic                      jalr_d, jalr_q;
  logic [2:0]                funct3_d, funct3_q;
  logic [DATA_WIDTH-1:0]     rd1_d, rd1_q;
  logic [DATA_WIDTH-1:0]     rd2_d, rd2_q;
  logic [DATA_WIDTH-1:0]     pc_d, pc_q;
  logic [DATA_WIDTH-1:0]     pc_plus4_d, pc_plus4_q;
  logic [DATA_WIDTH-1:0]     imm_ext_d, imm_ext_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_d, rs1_q;
  logic [REG_ADDR_WIDTH-1:0] rs2_d, rs2_q;
  logic [REG_ADDR_WIDTH-1:0] rd_d, rd_q;
  logic [CNT_WIDTH-1:0]      bubble_count_d, bubble_count_q;

  logic count_bubble;
  assign count_bubble = FlushE && (valid_q || ValidD)
                        && (bubble_count_q != {CNT_WIDTH{1'b1}});

  // Flush zeroes everything, including Rs/Rd, so forwarding never matches a bubble.
  always_comb begin
    valid_d        = valid_q;
    reg_write_d    = reg_write_q;
    result_src_d   = result_src_q;
    mem_write_d    = mem_write_q;
    alu_control_d  = alu_control_q;
    alu_src_d      = alu_src_q;
    jump_d         = jump_q;
    branch_d       = branch_q;
    jalr_d         = jalr_q;
    funct3_d       = funct3_q;
    rd1_d          = rd1_q;
    rd2_d          = rd2_q;
    pc_d           = pc_q;
    pc_plus4_d     = pc_plus4_q;
    imm_ext_d      = imm_ext_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    rd_d           = rd_q;
    bubble_count_d = bubble_count_q;
    if (FlushE) begin
      valid_d       = 1'b0;
      reg_write_d   = 1'b0;
      result_src_d  = '0;
      mem_write_d   = '0;
      alu_control_d = '0;
      alu_src_d     = 1'b0;
      jump_d        = 1'b0;
      branch_d      = 1'b0;
      jalr_d        = 1'b0;
      funct3_d      = '0;
      rd1_d         = '0;
      rd2_d         = '0;
      pc_d          = '0;
      pc_plus4_d    = '0;
      imm_ext_d     = '0;
      rs1_d         = '0;
      rs2_d         = '0;
      rd_d          = '0;
      if (count_bubble) begin
        bubble_count_d = bubble_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end else if (!StallE) begin
      valid_d       = ValidD;
      reg_write_d   = RegWriteD;
      result_src_d  = ResultSrcD;
      mem_write_d   = MemWriteD;
      alu_control_d = ALUControlD;
      alu_src_d     = ALUSrcD;
      jump_d        = JumpD;
      branch_d      = BranchD;
      jalr_d        = JalrD;
      funct3_d      = Funct3D;
      rd1_d         = RD1D;
      rd2_d         = RD2D;
      pc_d          = PCD;
      pc_plus4_d    = PCPlus4D;
      imm_ext_d     = ImmExtD;
      rs1_d         = Rs1D;
      rs2_d         = Rs2D;
      rd_d          = RdD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      result_src_q   <= '0;
      mem_write_q    <= '0;
      alu_control_q  <= '0;
      alu_src_q      <= 1'b0;
      jump_q         <= 1'b0;
      branch_q       <= 1'b0;
      jalr_q         <= 1'b0;
      funct3_q       <= '0;
      rd1_q          <= '0;
      rd2_q          <= '0;
      pc_q           <= '0;
      pc_plus4_q     <= '0;
      imm_ext_q      <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rd_q           <= '0;
      bubble_count_q <= '0;
    end else begin
      valid_q        <= valid_d;
      reg_write_q    <= reg_write_d;
      result_src_q   <= result_src_d;
      mem_write_q    <= mem_write_d;
      alu_control_q  <= alu_control_d;
      alu_src_q      <= alu_src_d;
      jump_q         <= jump_d;
      branch_q       <= branch_d;
      jalr_q         <= jalr_d;
      funct3_q       <= funct3_d;
      rd1_q          <= rd1_d;
      rd2_q          <= rd2_d;
      pc_q           <= pc_d;
      pc_plus4_q     <= pc_plus4_d;
      imm_ext_q      <= imm_ext_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      rd_q           <= rd_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign ValidE      = valid_q;
  assign RegWriteE   = reg_write_q;
  assign ResultSrcE  = result_src_q;
  assign MemWriteE   = mem_write_q;
  assign ALUControlE = alu_control_q;
  assign ALUSrcE     = alu_src_q;
  assign JumpE       = jump_q;
  assign BranchE     = branch_q;
  assign JalrE       = jalr_q;
  assign Funct3E     = funct3_q;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign PCE         = pc_q;
  assign PCPlus4E    = pc_plus4_q;
  assign ImmExtE     = imm_ext_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RdE         = rd_q;
  assign BubbleCount = bubble_count_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: a reference model pushes the expected stage
// contents each cycle; tests pop and compare after the edge. A 4-bit-counter copy checks saturation.
module tb_id_ex_pipeline_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallE = 1'b0, FlushE = 1'b0;
  logic        ValidD, RegWriteD, ALUSrcD, JumpD, BranchD, JalrD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  MemWriteD, ALUControlD, Funct3D;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;

  logic        ValidE, RegWriteE, ALUSrcE, JumpE, BranchE, JalrE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  MemWriteE, ALUControlE, Funct3E;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [15:0] BubbleCount;

  logic        s_ValidE, s_RegWriteE, s_ALUSrcE, s_JumpE, s_BranchE, s_JalrE;
  logic [1:0]  s_ResultSrcE;
  logic [2:0]  s_MemWriteE, s_ALUControlE, s_Funct3E;
  logic [31:0] s_RD1E, s_RD2E, s_PCE, s_PCPlus4E, s_ImmExtE;
  logic [4:0]  s_Rs1E, s_Rs2E, s_RdE;
  logic [3:0]  s_BubbleCount;

  always #5 clk = ~clk;

  id_ex_pipeline_reg dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .JumpD(JumpD), .BranchD(BranchD),
    .JalrD(JalrD), .Funct3D(Funct3D), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .JumpE(JumpE), .BranchE(BranchE),
    .JalrE(JalrE), .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .BubbleCount(BubbleCount)
  );

  id_ex_pipeline_reg #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .JumpD(JumpD), .BranchD(BranchD),
    .JalrD(JalrD), .Funct3D(Funct3D), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(s_ValidE), .RegWriteE(s_RegWriteE), .ResultSrcE(s_ResultSrcE),
    .MemWriteE(s_MemWriteE), .ALUControlE(s_ALUControlE), .ALUSrcE(s_ALUSrcE),
    .JumpE(s_JumpE), .BranchE(s_BranchE), .JalrE(s_JalrE), .Funct3E(s_Funct3E),
    .RD1E(s_RD1E), .RD2E(s_RD2E), .PCE(s_PCE), .PCPlus4E(s_PCPlus4E), .ImmExtE(s_ImmExtE),
    .Rs1E(s_Rs1E), .Rs2E(s_Rs2E), .RdE(s_RdE), .BubbleCount(s_BubbleCount)
  );

  // Observed vector: 192 bits of stage fields, 16-bit counter, 4-bit saturating counter.
  logic [211:0] obs;
  assign obs = {ValidE, RegWriteE, ResultSrcE, MemWriteE, ALUControlE, ALUSrcE, JumpE,
                BranchE, JalrE, Funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
                Rs1E, Rs2E, RdE, BubbleCount, s_BubbleCount};

  logic [211:0] sb[$];
  logic [211:0] exp_v;
  logic [191:0] m_state = '0;
  int           m_cnt = 0;
  int           m_cnt4 = 0;
  int           n_pass = 0;
  int           n_total = 0;

  task automatic drive_d(input logic [191:0] v);
    {ValidD, RegWriteD, ResultSrcD, MemWriteD, ALUControlD, ALUSrcD, JumpD, BranchD,
     JalrD, Funct3D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD} = v;
  endtask

  function automatic logic [191:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance the reference model with the inputs now applied, queue the expectation, clock once.
  task automatic step();
    logic [191:0] d_now;
    d_now = {ValidD, RegWriteD, ResultSrcD, MemWriteD, ALUControlD, ALUSrcD, JumpD, BranchD,
             JalrD, Funct3D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};
    if (rst) begin
      m_state = '0; m_cnt = 0; m_cnt4 = 0;
    end else if (FlushE) begin
      if (m_state[191] || ValidD) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      m_state = '0;
    end else if (!StallE) begin
      m_state = d_now;
    end
    sb.push_back({m_state, m_cnt[15:0], m_cnt4[3:0]});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    drive_d({192{1'b1}});
    for (int i = 0; i < 2; i++) begin
      step();
      exp_v = sb.pop_front(); n_total++;
      if (obs !== exp_v) $display("[TB] FAIL reset_all got=%h exp=%h", obs, exp_v);
      else n_pass++;
    end
    n_total++;
    if (BubbleCount !== 16'd0 || ValidE !== 1'b0)
      $display("[TB] FAIL reset_count got=%0d/%b exp=0/0", BubbleCount, ValidE);
    else n_pass++;
    rst = 1'b0;
    drive_d('0); ValidD = 1'b1; RegWriteD = 1'b1;
    step();
    exp_v = sb.pop_front(); n_total++;
    if (obs !== exp_v || RegWriteE !== 1'b1)
      $display("[TB] FAIL reset_release got=%h exp=%h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_pass_through();
    drive_d('0);
    ValidD = 1'b1; RegWriteD = 1'b1; ALUSrcD = 1'b1; ImmExtD = 32'h5; RdD = 5'd7;
    PCD = 32'h100; PCPlus4D = 32'h104; Rs1D = 5'd3;
    step();
    exp_v = sb.pop_front(); n_total++;
    if (obs !== exp_v) $display("[TB] FAIL addi_vec got=%h exp=%h", obs, exp_v);
    else n_pass++;
    n_total++;
    if ({ValidE, RegWriteE, ALUSrcE, ImmExtE, RdE, PCE} !== {3'b111, 32'h5, 5'd7, 32'h100})
      $display("[TB] FAIL addi_fields got=%b%b%b imm=%h rd=%0d pc=%h exp=111 imm=5 rd=7 pc=100",
               ValidE, RegWriteE, ALUSrcE, ImmExtE, RdE, PCE);
    else n_pass++;
    // Invalid decode slot still carries its control fields through unchanged.
    drive_d('0);
    ValidD = 1'b0; RegWriteD = 1'b1; MemWriteD = 3'd6; RdD = 5'd9;
    step();
    exp_v = sb.pop_front(); n_total++;
    if (obs !== exp_v || {ValidE, RegWriteE, MemWriteE} !== 5'b01110)
      $display("[TB] FAIL invalid_pass got=%h exp=%h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [191:0] v;
    drive_d('0);
    ValidD = 1'b1; MemWriteD = 3'b001; RD2D = 32'hDEADBEEF; Rs2D = 5'd4;
    step();
    exp_v = sb.pop_front(); n_total++;
    if (obs !== exp_v) $display("[TB] FAIL sw_load got=%h exp=%h", obs, exp_v);
    else n_pass++;
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_d(rand_vec());
      step();
      exp_v = sb.pop_front(); n_total++;
      if (obs !== exp_v || MemWriteE !== 3'd1 || RD2E !== 32'hDEADBEEF)
        $display("[TB] FAIL stall_hold got=%h exp=%h", obs, exp_v);
      else n_pass++;
    end
    StallE = 1'b0;
    v = rand_vec();
    v[191] = 1'b1;
    drive_d(v);
    step();
    exp_v = sb.pop_front(); n_total++;
    if (obs !== exp_v || RD2E !== RD2D)
      $display("[TB] FAIL stall_release got=%h exp=%h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_flush_vs_stall();
    drive_d('0);
    ValidD = 1'b1; RegWriteD = 1'b1; ResultSrcD = 2'b01; ALUSrcD = 1'b1; RdD = 5'd5;
    Funct3D = 3'b010; RD1D = 32'h1000; ImmExtD = 32'h8;
    step();
    exp_v = sb.pop_front(); n_total++;
    if (obs !== exp_v || RegWriteE !== 1'b1 || BubbleCount !== 16'd0)
      $display("[TB] FAIL lw_load got=%h exp=%h", obs, exp_v);
    else n_pass++;
    FlushE = 1'b1; StallE = 1'b1;
    drive_d(rand_vec());
    step();
    exp_v = sb.pop_front(); n_total++;
    if (obs !== exp_v || obs[211:20] !== '0 || BubbleCount !== 16'd1 || RdE !== 5'd0)
      $display("[TB] FAIL flush_over_stall got=%h exp=%h", obs, exp_v);
    else n_pass++;
    StallE = 1'b0;
  endtask

  task automatic test_empty_flush();
    logic [191:0] v;
    FlushE = 1'b1;
    v = rand_vec();
    v[191] = 1'b0;
    drive_d(v);
    step();
    exp_v = sb.pop_front(); n_total++;
    if (obs !== exp_v || BubbleCount !== 16'd1 || ValidE !== 1'b0)
      $display("[TB] FAIL empty_flush got=%h exp=%h", obs, exp_v);
    else n_pass++;
    ValidD = 1'b1;
    step();
    exp_v = sb.pop_front(); n_total++;
    if (obs !== exp_v || BubbleCount !== 16'd2)
      $display("[TB] FAIL arriving_flush got=%h exp=%h", obs, exp_v);
    else n_pass++;
    FlushE = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      drive_d(rand_vec());
      StallE = ($urandom_range(0, 3) == 0);
      FlushE = ($urandom_range(0, 4) == 0);
      step();
      exp_v = sb.pop_front(); n_total++;
      if (obs !== exp_v) $display("[TB] FAIL b2b_%0d got=%h exp=%h", i, obs, exp_v);
      else n_pass++;
    end
    StallE = 1'b0; FlushE = 1'b0;
  endtask

  task automatic test_saturation();
    FlushE = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_d(rand_vec());
      ValidD = 1'b1;
      step();
      exp_v = sb.pop_front(); n_total++;
      if (obs !== exp_v) $display("[TB] FAIL sat_flush_%0d got=%h exp=%h", i, obs, exp_v);
      else n_pass++;
    end
    n_total++;
    if (s_BubbleCount !== 4'd15) $display("[TB] FAIL sat_value got=%0d exp=15", s_BubbleCount);
    else n_pass++;
    FlushE = 1'b0;
    rst = 1'b1;
    step();
    exp_v = sb.pop_front(); n_total++;
    if (obs !== exp_v || s_BubbleCount !== 4'd0 || BubbleCount !== 16'd0)
      $display("[TB] FAIL sat_reset got=%h exp=%h", obs, exp_v);
    else n_pass++;
    rst = 1'b0;
    FlushE = 1'b1; ValidD = 1'b1;
    step();
    exp_v = sb.pop_front(); n_total++;
    if (obs !== exp_v || s_BubbleCount !== 4'd1)
      $display("[TB] FAIL sat_restart got=%h exp=%h", obs, exp_v);
    else n_pass++;
    FlushE = 1'b0;
  endtask

  initial begin
    drive_d('0);
    test_reset();
    test_pass_through();
    test_stall();
    test_flush_vs_stall();
    test_empty_flush();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
